// File: rtl/noc_input_buffers.sv
// noc_input_buffers
//   Per-port input FIFOs for the NoC router, each with a look-ahead XY route
//   decoder that holds the wormhole route for the rest of a packet.
//
// Ports
//   clk            : rising-edge clock
//   rst            : synchronous, active-low reset
//   in_flit_i      : incoming flits, port p at [p*FLIT_W +: FLIT_W]
//   in_valid_i     : flit present on port p
//   in_ready_o     : FIFO p has room
//   out_flit_o     : head flit of FIFO p
//   out_valid_o    : FIFO p non-empty
//   out_route_o    : one-hot route of the head flit, {L,W,E,S,N} per port
//   pop_i          : consume the head flit of FIFO p
//   count_o        : occupancy of FIFO p
//   overflow_err_o : sticky, a write arrived while FIFO p was full
module noc_input_buffers #(
  parameter int NUM_PORTS = 5,
  parameter int FLIT_W    = 16,
  parameter int DEPTH     = 4,
  parameter int COORD_W   = 4,
  parameter int MY_X      = 0,
  parameter int MY_Y      = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_PORTS*FLIT_W-1:0]            in_flit_i,
  input  logic [NUM_PORTS-1:0]                   in_valid_i,
  output logic [NUM_PORTS-1:0]                   in_ready_o,
  output logic [NUM_PORTS*FLIT_W-1:0]            out_flit_o,
  output logic [NUM_PORTS-1:0]                   out_valid_o,
  output logic [NUM_PORTS*5-1:0]                 out_route_o,
  input  logic [NUM_PORTS-1:0]                   pop_i,
  output logic [NUM_PORTS*$clog2(DEPTH+1)-1:0]   count_o,
  output logic [NUM_PORTS-1:0]                   overflow_err_o
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = $clog2(DEPTH+1);
  localparam logic [COORD_W-1:0] MyX = MY_X[COORD_W-1:0];
  localparam logic [COORD_W-1:0] MyY = MY_Y[COORD_W-1:0];

  typedef enum logic {
    IDLE,
    BODY
  } route_state_e;

  // Dimension-ordered XY routing: resolve X first, then Y, else eject locally.
  function automatic logic [4:0] xyDecode(input logic [COORD_W-1:0] dx,
                                          input logic [COORD_W-1:0] dy);
    logic [4:0] r;
    r = 5'b10000;
    if (dx > MyX)      r = 5'b00100;
    else if (dx < MyX) r = 5'b01000;
    else if (dy > MyY) r = 5'b00001;
    else if (dy < MyY) r = 5'b00010;
    return r;
  endfunction

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wrPtr_q;
    logic [PtrW-1:0]   rdPtr_q;
    logic [CntW-1:0]   count_q;
    logic [CntW-1:0]   count_d;
    logic              overflow_q;
    route_state_e      state_q;
    logic [4:0]        routeLatch_q;

    logic [FLIT_W-1:0] headFlit;
    logic [FLIT_W-1:0] inFlit;
    logic              notFull;
    logic              notEmpty;
    logic              doPush;
    logic              doPop;
    logic [4:0]        headDecode;
    logic [4:0]        headRoute;

    assign inFlit     = in_flit_i[p*FLIT_W +: FLIT_W];
    assign headFlit   = mem_q[rdPtr_q];
    assign notFull    = (count_q < CntW'(DEPTH));
    assign notEmpty   = (count_q != '0);
    assign doPush     = in_valid_i[p] & notFull;
    assign doPop      = pop_i[p] & notEmpty;
    assign headDecode = xyDecode(headFlit[2*COORD_W-1:COORD_W], headFlit[COORD_W-1:0]);

    // Occupancy bookkeeping; a simultaneous push and pop cancel out.
    always_comb begin
      count_d = count_q;
      if (doPush && !doPop)      count_d = count_q + CntW'(1);
      else if (!doPush && doPop) count_d = count_q - CntW'(1);
    end

    // Storage array carries no reset: stale entries are never visible because
    // validity comes from the count register.
    always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q] <= inFlit;
    end

    // Pointers, count and the sticky overflow flag.
    always_ff @(posedge clk) begin
      if (!rst) begin
        wrPtr_q    <= '0;
        rdPtr_q    <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        count_q <= count_d;
        if (doPush) wrPtr_q <= wrPtr_q + PtrW'(1);
        if (doPop)  rdPtr_q <= rdPtr_q + PtrW'(1);
        if (in_valid_i[p] && !notFull) overflow_q <= 1'b1;
      end
    end

    // Wormhole route FSM: a HEAD without TAIL pins its route until the TAIL
    // leaves. A non-HEAD popped in IDLE is a protocol error and changes nothing.
    always_ff @(posedge clk) begin
      if (!rst) begin
        state_q      <= IDLE;
        routeLatch_q <= '0;
      end else if (doPop) begin
        case (state_q)
          IDLE: begin
            if (headFlit[FLIT_W-1] && !headFlit[FLIT_W-2]) begin
              state_q      <= BODY;
              routeLatch_q <= headDecode;
            end
          end
          BODY: begin
            if (headFlit[FLIT_W-2]) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    // Route shown for the current head flit; zero when empty or when a
    // non-HEAD flit sits at the head outside a packet.
    always_comb begin
      headRoute = '0;
      if (notEmpty) begin
        if (state_q == BODY)         headRoute = routeLatch_q;
        else if (headFlit[FLIT_W-1]) headRoute = headDecode;
      end
    end

    assign in_ready_o[p]                 = notFull;
    assign out_valid_o[p]                = notEmpty;
    assign out_flit_o[p*FLIT_W +: FLIT_W] = headFlit;
    assign out_route_o[p*5 +: 5]         = headRoute;
    assign count_o[p*CntW +: CntW]       = count_q;
    assign overflow_err_o[p]             = overflow_q;
  end

endmodule

// File: tb/tb_noc_input_buffers.sv
module tb_noc_input_buffers;

   localparam int NP    = 5;
   localparam int FW    = 16;
   localparam int DEPTH = 4;
   localparam int CW    = 4;
   localparam int MYX   = 1;
   localparam int MYY   = 1;
   localparam int CNTW  = $clog2(DEPTH+1);

   localparam logic [4:0] R_N = 5'b00001;
   localparam logic [4:0] R_S = 5'b00010;
   localparam logic [4:0] R_E = 5'b00100;
   localparam logic [4:0] R_W = 5'b01000;
   localparam logic [4:0] R_L = 5'b10000;

   logic              clk = 1'b0;
   logic              rst;
   logic [NP*FW-1:0]  inFlit;
   logic [NP-1:0]     stimValid;
   logic [NP-1:0]     inReady;
   logic [NP*FW-1:0]  outFlit;
   logic [NP-1:0]     outValid;
   logic [NP*5-1:0]   outRoute;
   logic [NP-1:0]     stimPop;
   logic [NP*CNTW-1:0] countOut;
   logic [NP-1:0]     overflowErr;
   logic [FW-1:0]     stimFlit [NP];

   int nChecks = 0;
   int nFails  = 0;

   // Reference model: one queue per port plus packet-level route tracking.
   typedef logic [FW-1:0] flitQueue_t [$];
   flitQueue_t modelQ [NP];
   bit         modelBody  [NP];
   logic [4:0] modelLatch [NP];
   bit         modelOvf   [NP];

   for (genvar g = 0; g < NP; g++) begin : g_pack
      assign inFlit[g*FW +: FW] = stimFlit[g];
   end

   noc_input_buffers #(
      .NUM_PORTS(NP), .FLIT_W(FW), .DEPTH(DEPTH), .COORD_W(CW), .MY_X(MYX), .MY_Y(MYY)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_flit_i(inFlit),
      .in_valid_i(stimValid),
      .in_ready_o(inReady),
      .out_flit_o(outFlit),
      .out_valid_o(outValid),
      .out_route_o(outRoute),
      .pop_i(stimPop),
      .count_o(countOut),
      .overflow_err_o(overflowErr)
   );

   always #5 clk = ~clk;

   // Compare one observed value with its expected value and log any miscompare.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FW-1:0] mkFlit(input int h, input int t, input int x, input int y, input int pl);
      logic [FW-1:0] f;
      f = {h[0], t[0], pl[5:0], x[3:0], y[3:0]};
      return f;
   endfunction

   // XY routing straight from the rule list: X first, then Y, else local.
   function automatic logic [4:0] xyRoute(input logic [FW-1:0] f);
      int dx;
      int dy;
      dx = int'(f[2*CW-1:CW]);
      dy = int'(f[CW-1:0]);
      if (dx > MYX) return R_E;
      if (dx < MYX) return R_W;
      if (dy > MYY) return R_N;
      if (dy < MYY) return R_S;
      return R_L;
   endfunction

   function automatic logic [4:0] expRoute(input int p);
      if (modelQ[p].size() == 0) return 5'b0;
      if (modelBody[p]) return modelLatch[p];
      if (modelQ[p][0][FW-1]) return xyRoute(modelQ[p][0]);
      return 5'b0;
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic modelStep();
      logic [FW-1:0] head;
      for (int p = 0; p < NP; p++) begin
         if (!rst) begin
            modelQ[p].delete();
            modelBody[p]  = 1'b0;
            modelLatch[p] = 5'b0;
            modelOvf[p]   = 1'b0;
         end else begin
            bit hasRoom;
            bit doPop;
            hasRoom = (modelQ[p].size() < DEPTH);
            doPop   = stimPop[p] && (modelQ[p].size() > 0);
            if (stimValid[p] && !hasRoom) modelOvf[p] = 1'b1;
            if (doPop) begin
               head = modelQ[p].pop_front();
               if (!modelBody[p]) begin
                  if (head[FW-1] && !head[FW-2]) begin
                     modelBody[p]  = 1'b1;
                     modelLatch[p] = xyRoute(head);
                  end
               end else if (head[FW-2]) begin
                  modelBody[p] = 1'b0;
               end
            end
            if (stimValid[p] && hasRoom) modelQ[p].push_back(stimFlit[p]);
         end
      end
   endtask

   task automatic checkAllPorts();
      for (int p = 0; p < NP; p++) begin
         checkOutput($sformatf("p%0d_ready", p), 32'(inReady[p]), 32'(modelQ[p].size() < DEPTH));
         checkOutput($sformatf("p%0d_valid", p), 32'(outValid[p]), 32'(modelQ[p].size() > 0));
         checkOutput($sformatf("p%0d_count", p), 32'(countOut[p*CNTW +: CNTW]), 32'(modelQ[p].size()));
         checkOutput($sformatf("p%0d_ovf", p), 32'(overflowErr[p]), 32'(modelOvf[p]));
         checkOutput($sformatf("p%0d_route", p), 32'(outRoute[p*5 +: 5]), 32'(expRoute(p)));
         if (modelQ[p].size() > 0)
            checkOutput($sformatf("p%0d_flit", p), 32'(outFlit[p*FW +: FW]), 32'(modelQ[p][0]));
      end
   endtask

   // One clock: check outputs mid-cycle, then let the edge update DUT and model.
   task automatic applyStimulus();
      @(negedge clk);
      checkAllPorts();
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic clearInputs();
      stimValid = '0;
      stimPop   = '0;
      for (int p = 0; p < NP; p++) stimFlit[p] = '0;
   endtask

   task automatic doReset();
      clearInputs();
      rst = 1'b0;
      applyStimulus();
      rst = 1'b1;
   endtask

   int dirX [5] = '{2, 0, 1, 1, 1};
   int dirY [5] = '{1, 1, 2, 0, 1};
   logic [4:0] dirExp [5];
   logic [FW-1:0] saved [5];

   initial begin
      dirExp = '{R_E, R_W, R_N, R_S, R_L};
      rst = 1'b1;
      clearInputs();
      doReset();
      applyStimulus();
      checkOutput("rst_ready", 32'(inReady), 32'(5'b11111));
      checkOutput("rst_valid", 32'(outValid), 32'(0));
      checkOutput("rst_route", 32'(outRoute), 32'(0));
      checkOutput("rst_count", 32'(countOut), 32'(0));

      // Port 0: single-flit packets toward every direction.
      for (int i = 0; i < 5; i++) begin
         stimFlit[0] = mkFlit(1, 1, dirX[i], dirY[i], int'($urandom_range(0, 63)));
         stimValid[0] = 1'b1;
         applyStimulus();
         stimValid[0] = 1'b0;
         checkOutput("p0_dir", 32'(outRoute[4:0]), 32'(dirExp[i]));
         stimPop[0] = 1'b1;
         applyStimulus();
         stimPop[0] = 1'b0;
      end

      // Port 2: four-flit wormhole packet, then a fresh head toward (0,0).
      for (int i = 0; i < 4; i++) begin
         stimFlit[2] = mkFlit(i == 0, i == 3, (i == 0) ? 3 : int'($urandom_range(0, 15)),
                              (i == 0) ? 0 : int'($urandom_range(0, 15)), int'($urandom_range(0, 63)));
         stimValid[2] = 1'b1;
         applyStimulus();
      end
      stimValid[2] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checkOutput("p2_worm", 32'(outRoute[2*5 +: 5]), 32'(R_E));
         stimPop[2] = 1'b1;
         applyStimulus();
      end
      stimPop[2] = 1'b0;
      stimFlit[2] = mkFlit(1, 0, 0, 0, 5);
      stimValid[2] = 1'b1;
      applyStimulus();
      stimValid[2] = 1'b0;
      checkOutput("p2_newhead", 32'(outRoute[2*5 +: 5]), 32'(R_W));

      // Port 1: overfill by one, then drain in order.
      for (int i = 0; i < 5; i++) begin
         saved[i] = mkFlit(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), i + 1);
         stimFlit[1] = saved[i];
         stimValid[1] = 1'b1;
         applyStimulus();
         if (i == 3) begin
            checkOutput("p1_full_ready", 32'(inReady[1]), 32'(0));
            checkOutput("p1_full_count", 32'(countOut[1*CNTW +: CNTW]), 32'(4));
         end
      end
      stimValid[1] = 1'b0;
      checkOutput("p1_ovf", 32'(overflowErr[1]), 32'(1));
      for (int i = 0; i < 4; i++) begin
         checkOutput("p1_order", 32'(outFlit[1*FW +: FW]), 32'(saved[i]));
         stimPop[1] = 1'b1;
         applyStimulus();
      end
      stimPop[1] = 1'b0;
      checkOutput("p1_ovf_sticky", 32'(overflowErr[1]), 32'(1));

      // Port 3: streaming push and pop across pointer wrap.
      for (int i = 0; i < 3*DEPTH; i++) begin
         stimFlit[3] = mkFlit(1, 1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), i);
         stimValid[3] = 1'b1;
         stimPop[3] = 1'b1;
         applyStimulus();
         checkOutput("p3_stream_count", 32'(countOut[3*CNTW +: CNTW]), 32'(1));
      end
      stimValid[3] = 1'b0;
      applyStimulus();
      stimPop[3] = 1'b0;
      checkOutput("p3_no_err", 32'(overflowErr[3]), 32'(0));

      // Port 4: reset in the middle of a packet.
      for (int i = 0; i < 3; i++) begin
         stimFlit[4] = mkFlit(i == 0, 0, 2, 2, i);
         stimValid[4] = 1'b1;
         applyStimulus();
      end
      stimValid[4] = 1'b0;
      stimPop[4] = 1'b1;
      applyStimulus();
      stimPop[4] = 1'b0;
      checkOutput("p4_body_route", 32'(outRoute[4*5 +: 5]), 32'(R_E));
      doReset();
      checkOutput("p4_rst_valid", 32'(outValid[4]), 32'(0));
      checkOutput("p4_rst_count", 32'(countOut[4*CNTW +: CNTW]), 32'(0));
      stimFlit[4] = mkFlit(0, 0, 3, 3, 9);
      stimValid[4] = 1'b1;
      applyStimulus();
      stimValid[4] = 1'b0;
      checkOutput("p4_idle_route", 32'(outRoute[4*5 +: 5]), 32'(0));
      checkOutput("p4_idle_valid", 32'(outValid[4]), 32'(1));

      // Random traffic on all ports with an occasional reset.
      doReset();
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < NP; p++) begin
            stimValid[p] = ($urandom_range(0, 99) < 60);
            stimPop[p]   = ($urandom_range(0, 99) < 50);
            stimFlit[p]  = mkFlit(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                                  int'($urandom_range(0, 63)));
         end
         rst = ($urandom_range(0, 99) != 0);
         applyStimulus();
      end
      rst = 1'b1;
      clearInputs();
      applyStimulus();

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/noc_input_buffers.md
# noc_input_buffers

Parametrised set of per-port input FIFOs for the NoC router. Each port has a valid/ready write side and a head-of-queue read side with a pop strobe. Each port also has a look-ahead XY route decoder that holds a wormhole route across the packet. It sits between the router's link inputs and the switch allocator/crossbar, and replaces the fixed five-port 16-bit input queue stage.

## Interface
Parameters:
- NUM_PORTS, 5, number of input channels (index 0..NUM_PORTS-1)
- FLIT_W, 16, flit width in bits (minimum 2*COORD_W+2)
- DEPTH, 4, entries per FIFO (power of two, ≥2)
- COORD_W, 4, width of each destination coordinate
- MY_X, 0, this router's X coordinate
- MY_Y, 0, this router's Y coordinate

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- in_flit_i  in  NUM_PORTS*FLIT_W  incoming flits; port p at [p*FLIT_W +: FLIT_W]
- in_valid_i  in  NUM_PORTS  flit present on port p
- in_ready_o  out  NUM_PORTS  FIFO p not full
- out_flit_o  out  NUM_PORTS*FLIT_W  head flit of FIFO p
- out_valid_o  out  NUM_PORTS  FIFO p non-empty
- out_route_o  out  NUM_PORTS*5  one-hot route of head flit, bit order {L,W,E,S,N} = [4:0]
- pop_i  in  NUM_PORTS  consume head flit of FIFO p
- count_o  out  NUM_PORTS*$clog2(DEPTH+1)  occupancy of FIFO p
- overflow_err_o  out  NUM_PORTS  sticky: a write was attempted while FIFO p was full

## Operation
- Flit format: bit FLIT_W-1 = HEAD, bit FLIT_W-2 = TAIL, dest X = [2*COORD_W-1:COORD_W], dest Y = [COORD_W-1:0]. HEAD and TAIL both set means a single-flit packet.
- Push: in_valid_i[p] & in_ready_o[p] writes the flit at wr_ptr, advances wr_ptr mod DEPTH and increments the count.
- in_valid_i[p] & ~in_ready_o[p]: the flit is dropped, overflow_err_o[p] is set, and it stays set until reset.
- Pop: pop_i[p] & out_valid_o[p] advances rd_ptr mod DEPTH and decrements the count. A pop with out_valid_o[p]=0 is ignored and has no error.
- Simultaneous push and pop on a non-empty, non-full FIFO leaves count unchanged and both pointers advance.
- in_ready_o[p] = (count < DEPTH). There is no pop-bypass when full.
- Route decode (XY, dimension-ordered) on the head flit:
  - dx > MY_X → E
  - dx < MY_X → W
  - else dy > MY_Y → N
  - else dy < MY_Y → S
  - else L
  - Comparisons are unsigned.
- Per-port route FSM:
  - IDLE: out_route_o[p] = decode(head flit) when the head is HEAD, else 0.
  - Popping a HEAD without TAIL latches the decoded route and moves to BODY.
  - BODY: out_route_o[p] = latched route for every head flit, whatever its HEAD bit.
  - Popping a TAIL flit returns to IDLE.
  - A non-HEAD flit at the head in IDLE is a protocol error: out_route_o[p] = 0 and the flit may still be popped.
- out_route_o[p] = 0 whenever out_valid_o[p] = 0.
- Ports are fully independent; there is no shared state.

## Timing
- Reset (rst=0 at a clock edge) clears all pointers, counts, FSMs (to IDLE) and overflow_err_o. After reset: in_ready_o = all 1, out_valid_o = 0, out_route_o = 0, count_o = 0, overflow_err_o = 0.
- Reset asserted mid-packet discards all stored flits. No partial state survives.
- Write-to-read latency: a flit accepted at edge n appears on out_flit_o/out_valid_o after edge n; it is poppable in cycle n+1.
- out_flit_o, out_valid_o, out_route_o, in_ready_o and count_o are functions of registered state only, with no combinational path from inputs. The route decode is combinational from the head entry.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full/empty is derived from the count register.
- Push into an empty FIFO concurrent with pop_i: the pop is ignored and count becomes 1.

## Test plan
- Reset, then idle on all ports → in_ready_o=5'b11111, out_valid_o=0, count_o all 0, out_route_o=0.
- MY_X=1, MY_Y=1. Port 0 receives single-flit packets with dest (2,1), (0,1), (1,2), (1,0), (1,1) → out_route_o[4:0] reads E, W, N, S, L in turn; FSM stays IDLE after each pop.
- Port 2 receives a 4-flit packet: HEAD dest (3,0), two body flits, then TAIL, each with random low bits → route E on all four flits; after the TAIL pop, a new HEAD dest (0,0) decodes W.
- Port 1: push 5 flits with no pops at DEPTH=4 → 4th push makes in_ready_o[1]=0 and count=4; 5th flit dropped, overflow_err_o[1]=1; pops return flits 1–4 in order and the error bit stays 1.
- Port 3: continuous push and pop for 3·DEPTH cycles → count steady at 1, data in order across pointer wrap, no error.
- Port 4: mid-packet (BODY state, 2 flits queued), drive rst=0 for one cycle → next cycle out_valid_o[4]=0, count=0; a following body-only flit gives out_route_o[4]=0 (IDLE).
